// File: rtl/spi_master_dp.sv
// SPI master datapath: TX holding register, MSB-first shift register and RX
// buffer driven by the controller's load/shift_en/ss strobes.
module spi_master_dp #(
    parameter int unsigned       DATA_W = 16,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              load,
    input  logic              shift_en,
    input  logic              ss,
    output logic              mosi,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              underrun,
    output logic              overrun,
    output logic              frame_err,
    input  logic              clr_flags
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    logic [DATA_W-1:0] shifted;
    logic              capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcnt_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        // Clear first so any set event below in the same cycle overrides it.
        underrun_d  = underrun_q  & ~clr_flags;
        overrun_d   = overrun_q   & ~clr_flags;
        frame_err_d = frame_err_q & ~clr_flags;
        capture     = 1'b0;
        shifted     = {shreg_q[DATA_W-2:0], miso};

        if (load) begin
            shreg_d     = hold_full_q ? hold_q : FILL;
            hold_full_d = 1'b0;
            bcnt_d      = '0;
            state_d     = LOADED;
            if (!hold_full_q) begin
                underrun_d = 1'b1;
            end
            if (state_q == SHIFT && bcnt_q != '0 && bcnt_q < FULL_CNT) begin
                frame_err_d = 1'b1;
            end
        end else if (ss && state_q != IDLE) begin
            state_d     = IDLE;
            frame_err_d = 1'b1;
        end else if (shift_en) begin
            if (state_q == IDLE) begin
                frame_err_d = 1'b1;
            end else begin
                shreg_d = shifted;
                bcnt_d  = bcnt_q + 1'b1;
                state_d = SHIFT;
                if (bcnt_q == LAST_BIT) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
        end

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (capture) begin
            rx_data_d  = shifted;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end
        end

        // Accept after the load clear: an accept on an underrun load refills hold.
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    assign tx_ready  = ~hold_full_q;
    assign mosi      = shreg_q[DATA_W-1];
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_master_dp.sv
// Randomized and directed bench for spi_master_dp against a word-level
// reference model of the frame, handshake and flag rules.
module tb_spi_master_dp;

    localparam int unsigned W = 16;
    localparam logic [W-1:0] FILL_W = 16'hFFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic         load = 1'b0;
    logic         shift_en = 1'b0;
    logic         ss = 1'b0;
    logic         mosi;
    logic         miso = 1'b0;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         busy;
    logic         underrun;
    logic         overrun;
    logic         frame_err;
    logic         clr_flags = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: phase 0 = idle, 1 = loaded, 2 = shifting; m_n bits done.
    logic [W-1:0] m_hold, m_sh, m_rxd;
    logic         m_hold_full, m_rxv, m_ur, m_ov, m_fe;
    int           m_phase, m_n;

    spi_master_dp #(
        .DATA_W(W),
        .FILL  (FILL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .load     (load),
        .shift_en (shift_en),
        .ss       (ss),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .underrun (underrun),
        .overrun  (overrun),
        .frame_err(frame_err),
        .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = '0; m_sh = '0; m_rxd = '0;
        m_hold_full = 1'b0; m_rxv = 1'b0;
        m_ur = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        m_phase = 0; m_n = 0;
    endtask

    task automatic model_step();
        logic accept, old_rxv, cap;
        accept  = tx_valid && !m_hold_full;
        old_rxv = m_rxv;
        cap     = 1'b0;
        if (clr_flags) begin
            m_ur = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        end
        if (load) begin
            if (m_phase == 2 && m_n > 0 && m_n < W) m_fe = 1'b1;
            if (!m_hold_full) m_ur = 1'b1;
            m_sh = m_hold_full ? m_hold : FILL_W;
            m_hold_full = 1'b0;
            m_n = 0;
            m_phase = 1;
        end else if (ss && m_phase != 0) begin
            m_phase = 0;
            m_fe = 1'b1;
        end else if (shift_en) begin
            if (m_phase == 0) begin
                m_fe = 1'b1;
            end else begin
                m_sh = W'((m_sh * 2) + miso);
                m_n++;
                m_phase = 2;
                if (m_n == W) begin
                    cap = 1'b1;
                    m_phase = 0;
                end
            end
        end
        if (old_rxv && rx_ready) m_rxv = 1'b0;
        if (cap) begin
            if (old_rxv && !rx_ready) m_ov = 1'b1;
            m_rxd = m_sh;
            m_rxv = 1'b1;
        end
        if (accept) begin
            m_hold = tx_data;
            m_hold_full = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("mosi",      32'(mosi),      32'(m_sh[W-1]));
        chk("tx_ready",  32'(tx_ready),  32'(!m_hold_full));
        chk("rx_valid",  32'(rx_valid),  32'(m_rxv));
        chk("rx_data",   32'(rx_data),   32'(m_rxd));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("underrun",  32'(underrun),  32'(m_ur));
        chk("overrun",   32'(overrun),   32'(m_ov));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_mosi"},      32'(mosi),      32'd0);
        chk({pfx, "_tx_ready"},  32'(tx_ready),  32'd1);
        chk({pfx, "_rx_valid"},  32'(rx_valid),  32'd0);
        chk({pfx, "_rx_data"},   32'(rx_data),   32'd0);
        chk({pfx, "_busy"},      32'(busy),      32'd0);
        chk({pfx, "_underrun"},  32'(underrun),  32'd0);
        chk({pfx, "_overrun"},   32'(overrun),   32'd0);
        chk({pfx, "_frame_err"}, 32'(frame_err), 32'd0);
    endtask

    task automatic write_word(input logic [W-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [W-1:0] miso_w, output logic [W-1:0] seq);
        ss   = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            seq[i]   = mosi;
            miso     = miso_w[i];
            shift_en = 1'b1;
            step();
        end
        shift_en = 1'b0;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    initial begin
        logic [W-1:0] seq;

        // Power-on reset, asserted between clock edges.
        #3 rst = 1'b1;
        #1 check_reset_values("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();

        // Normal frame.
        write_word(16'hA5C3);
        run_frame(16'h3C5A, seq);
        chk("normal_mosi_seq", 32'(seq), 32'h0000A5C3);
        chk("normal_rx_data",  32'(rx_data), 32'h00003C5A);
        chk("normal_rx_valid", 32'(rx_valid), 32'd1);
        chk("normal_flags",    32'({underrun, overrun, frame_err}), 32'd0);
        drain();

        // Asynchronous reset seven bits into a frame.
        write_word(16'h8001);
        ss   = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            miso     = 1'b1;
            shift_en = 1'b1;
            step();
        end
        shift_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();

        // Underrun: empty holding register transmits FILL.
        run_frame(W'($urandom), seq);
        chk("underrun_mosi_seq", 32'(seq), 32'h0000FFFF);
        chk("underrun_flag",     32'(underrun), 32'd1);
        chk("underrun_tx_ready", 32'(tx_ready), 32'd1);
        drain();
        pulse_clr();

        // Overrun: two frames with nobody consuming.
        write_word(16'h1357);
        run_frame(16'h1111, seq);
        write_word(16'h2468);
        run_frame(16'h2222, seq);
        chk("overrun_flag",     32'(overrun), 32'd1);
        chk("overrun_rx_data",  32'(rx_data), 32'h00002222);
        chk("overrun_rx_valid", 32'(rx_valid), 32'd1);
        drain();
        pulse_clr();

        // Abort after five shifts, then a clean frame, then clear flags.
        write_word(16'h5A5A);
        ss   = 1'b0;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            miso     = 1'($urandom);
            shift_en = 1'b1;
            step();
        end
        shift_en = 1'b0;
        ss = 1'b1;
        step();
        chk("abort_frame_err", 32'(frame_err), 32'd1);
        chk("abort_rx_valid",  32'(rx_valid), 32'd0);
        chk("abort_busy",      32'(busy), 32'd0);
        ss = 1'b0;
        write_word(16'h0F0F);
        run_frame(16'h1234, seq);
        chk("abort_next_rx_data", 32'(rx_data), 32'h00001234);
        chk("abort_next_mosi",    32'(seq), 32'h00000F0F);
        pulse_clr();
        chk("abort_clr", 32'(frame_err), 32'd0);
        drain();

        // TX backpressure: hold tx_valid across two words.
        tx_data  = 16'h0001;
        tx_valid = 1'b1;
        step();
        chk("bp_first_accept", 32'(tx_ready), 32'd0);
        tx_data = 16'h0002;
        step();
        step();
        chk("bp_held", 32'(tx_ready), 32'd0);
        run_frame(W'($urandom), seq);
        chk("bp_frame1_mosi", 32'(seq), 32'h00000001);
        chk("bp_second_held", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
        run_frame(W'($urandom), seq);
        chk("bp_frame2_mosi", 32'(seq), 32'h00000002);
        chk("bp_no_underrun", 32'(underrun), 32'd0);
        drain();

        // Randomized strobes against the model.
        for (int c = 0; c < 4000; c++) begin
            tx_data   = W'($urandom);
            tx_valid  = 1'($urandom);
            load      = ($urandom_range(0, 19) == 0);
            shift_en  = ($urandom_range(0, 7) != 0);
            ss        = ($urandom_range(0, 39) == 0);
            miso      = 1'($urandom);
            rx_ready  = ($urandom_range(0, 2) == 0);
            clr_flags = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
